spi_master_core: RTL and testbench
==================================

// Module: spi_master_core
// PURPOSE
//   Parametrised SPI master. Combines SCLK generation (divider, CPOL, edge strobes) with
//   the shift engine, supporting all four CPOL/CPHA modes, a runtime word length,
//   MSB- or LSB-first order and NCS chip selects. Sits between the register/bus
//   interface (start/done handshake) and the SPI pins.
// PARAMETERS
//   N      8   divider width; SCLK half-period = (divider_i+1) sysclk cycles
//   MAXW   32  maximum word length in bits; width of tx/rx data
//   NCS    4   number of chip-select outputs (>=1)
// PORTS
//   sysclk     in   1               system clock, all logic on rising edge
//   rst_n      in   1               reset, asynchronous, active-low
//   enable     in   1               block enable; low = abort and hold idle
//   start_i    in   1               1-cycle request; sampled only in IDLE with enable=1
//   cpol_i     in   1               clock polarity (SCLK idle level)
//   cpha_i     in   1               clock phase
//   lsb_first_i in  1               1 = shift LSB first
//   char_len_i in   $clog2(MAXW)    bits per word; 0 means MAXW
//   divider_i  in   N               SCLK half-period minus one
//   cs_sel_i   in   $clog2(NCS)     chip-select index (max(1,...) bits)
//   tx_data_i  in   MAXW            word to send, right-justified
//   miso_i     in   1               serial data in
//   sclk_o     out  1               SPI clock
//   mosi_o     out  1               serial data out
//   cs_n_o     out  NCS             active-low chip selects, at most one low
//   busy_o     out  1               high from accepted start until done/abort
//   done_o     out  1               1-cycle pulse, rx_data_o valid
//   rx_data_o  out  MAXW            received word, right-justified, upper bits zero
// BEHAVIOUR
// - Reset: sclk_o=0, mosi_o=0, cs_n_o=all 1, busy_o=0, done_o=0, rx_data_o=0, state IDLE.
// - All config inputs latched on start acceptance; changes mid-transfer ignored.
// - start_i while busy_o=1 or enable=0 is ignored (no queuing).
// - Half-period tick: counter reloads to divider_i, tick when it reaches 0.
//   divider_i=0 gives SCLK = sysclk/2.
// - FSM IDLE->LEAD->XFER->TRAIL->DONE->IDLE:
//   IDLE: sclk_o=cpol_i (live), cs_n_o all 1.
//   LEAD: cycle after accept: cs_n_o[cs_sel]=0, busy_o=1, sclk_o=CPOL;
//         CPHA=0 drives the first bit on mosi_o now. Lasts one half-period.
//   XFER: 2*len half-periods; each tick toggles sclk_o. Leading edge: CPHA=0
//         samples miso, CPHA=1 shifts out. Trailing edge: opposite action.
//         CPHA=1 drives the first bit at the first leading edge.
//   TRAIL: sclk_o back at CPOL, CS held low one half-period, then released.
//   DONE: cs_n_o all 1, done_o=1 for one cycle, busy_o falls the same cycle.
//         rx_data_o updated that cycle and held until the next DONE.
// - Bit order: MSB-first sends tx_data_i[len-1] first; LSB-first sends bit 0
//   first. rx is assembled so bit k of rx_data_o is the k-th bit of word weight.
// - Latency, start accept to done_o: (2*len+2)*(divider_i+1)+2 cycles.
// - enable low mid-transfer: next cycle go to IDLE, cs_n_o all 1, sclk_o=CPOL,
//   no done_o, rx_data_o unchanged. rst_n low does the same asynchronously,
//   using reset values.
// - cs_sel_i >= NCS: no CS asserted; transfer still runs.
// CONFIGURATION
// - SPI_LOOPBACK_EN defined: extra input loopback_i. When the latched value is 1,
//   internal miso = mosi_o and miso_i is ignored, so rx_data_o == tx_data_i per
//   transfer. Not defined: port absent, miso_i is always used.
// TESTING
// - Mode 0, div=4, len=8, tx=0xA5, miso tied to mosi -> rx=0xA5;
//   done_o at (18*5)+2 cycles; 8 rising SCLK edges; cs_n_o[0] low throughout.
// - Modes 1/2/3 with a slave model sending 0x3C -> rx=0x3C; sclk idle = CPOL
//   before and after each transfer.
// - lsb_first=1, len=12, tx=0x5A3 -> mosi sequence 1,1,0,0,0,1,0,1,1,0,1,0.
//   len=0 -> 32 SCLK cycles.
// - Second start_i while busy ignored. cs_sel=2 asserts only cs_n_o[2].
//   divider=0 -> SCLK period = 2 sysclk cycles.
// - enable dropped after 3 SCLK cycles -> cs_n_o=4'hF next cycle, no done_o,
//   rx_data_o keeps its previous value. rst_n pulse mid-transfer -> reset values.
// - With SPI_LOOPBACK_EN, loopback_i=1, miso_i=0, tx=0xFFFF_0001, len=0
//   -> rx=0xFFFF_0001.

Source files
------------

// File: rtl/spi_master_core.sv
// spi_master_core: SPI master with SCLK divider, all CPOL/CPHA modes, runtime word length and chip selects
// Ports: sysclk/rst_n (async active-low), enable, start_i/busy_o/done_o handshake,
// cpol_i/cpha_i/lsb_first_i/char_len_i/divider_i/cs_sel_i/tx_data_i config latched on start,
// miso_i/sclk_o/mosi_o/cs_n_o SPI pins, rx_data_o received word.
// Optional SPI_LOOPBACK_EN adds loopback_i: when latched high, mosi_o is sampled instead of miso_i.
module spi_master_core #(
  parameter int N = 8,
  parameter int MAXW = 32,
  parameter int NCS = 4,
  localparam int W = $clog2(MAXW),
  localparam int CSW = NCS > 1 ? $clog2(NCS) : 1
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            start_i,
  input  logic            cpol_i,
  input  logic            cpha_i,
  input  logic            lsb_first_i,
  input  logic [W-1:0]    char_len_i,
  input  logic [N-1:0]    divider_i,
  input  logic [CSW-1:0]  cs_sel_i,
  input  logic [MAXW-1:0] tx_data_i,
  input  logic            miso_i,
`ifdef SPI_LOOPBACK_EN
  input  logic            loopback_i,
`endif
  output logic            sclk_o,
  output logic            mosi_o,
  output logic [NCS-1:0]  cs_n_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [MAXW-1:0] rx_data_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEAD = 3'd1;
  localparam logic [2:0] XFER = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0] state;
  logic [N-1:0] cnt, div_q;
  logic [W:0] len_q, len_in, t, j, dj;
  logic [W-1:0] lm1;
  logic cpha_q, lsb_q, tick, samp, last, miso_int;
  logic [MAXW-1:0] tx_q, rx_sh;
  logic [NCS-1:0] cs_dec;
`ifdef SPI_LOOPBACK_EN
  logic lb_q;
`endif
  // bit position within the word of the k-th bit on the wire
  function automatic logic [W-1:0] pos(input logic lsb, input logic [W:0] l, input logic [W:0] k);
    return W'(lsb ? k : l - 1'b1 - k);
  endfunction
  always_comb begin
    len_in = char_len_i == '0 ? (W+1)'(MAXW) : {1'b0, char_len_i};
    tick = cnt == '0;
    j = {1'b0, t[W:1]};
    // even ticks are leading edges; CPHA selects which edge samples
    samp = t[0] == cpha_q;
    dj = j + {{W{1'b0}}, ~cpha_q};
    lm1 = W'(len_q - 1'b1);
    last = t == {lm1, 1'b1};
`ifdef SPI_LOOPBACK_EN
    miso_int = lb_q ? mosi_o : miso_i;
`else
    miso_int = miso_i;
`endif
    for (int i = 0; i < NCS; i++) cs_dec[i] = cs_sel_i != CSW'(i);
  end
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      div_q <= '0;
      len_q <= '0;
      t <= '0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      tx_q <= '0;
      rx_sh <= '0;
      sclk_o <= 1'b0;
      mosi_o <= 1'b0;
      cs_n_o <= '1;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      rx_data_o <= '0;
`ifdef SPI_LOOPBACK_EN
      lb_q <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cs_n_o <= '1;
        sclk_o <= cpol_i;
        busy_o <= 1'b0;
      end else begin
        if (state == LEAD || state == XFER || state == TRAIL) cnt <= tick ? div_q : cnt - 1'b1;
        case (state)
          IDLE: begin
            sclk_o <= cpol_i;
            cs_n_o <= '1;
            if (start_i) begin
              state <= LEAD;
              cnt <= divider_i;
              div_q <= divider_i;
              len_q <= len_in;
              cpha_q <= cpha_i;
              lsb_q <= lsb_first_i;
              tx_q <= tx_data_i;
              rx_sh <= '0;
              t <= '0;
              busy_o <= 1'b1;
              cs_n_o <= cs_dec;
              if (!cpha_i) mosi_o <= tx_data_i[pos(lsb_first_i, len_in, '0)];
`ifdef SPI_LOOPBACK_EN
              lb_q <= loopback_i;
`endif
            end
          end
          LEAD: if (tick) state <= XFER;
          XFER: if (tick) begin
            sclk_o <= ~sclk_o;
            t <= t + 1'b1;
            if (samp) rx_sh[pos(lsb_q, len_q, j)] <= miso_int;
            else if (dj < len_q) mosi_o <= tx_q[pos(lsb_q, len_q, dj)];
            if (last) state <= TRAIL;
          end
          // CS is released one cycle ahead of the done pulse
          TRAIL: if (tick) begin
            state <= DONE;
            cs_n_o <= '1;
          end
          DONE: begin
            state <= IDLE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            rx_data_o <= rx_sh;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_master_core.sv
// tb_spi_master_core: randomized bench with an SPI slave reference model for spi_master_core
module tb_spi_master_core;
  logic sysclk = 1'b0, rst_n = 1'b0, enable = 1'b0, start_i = 1'b0;
  logic cpol_i = 1'b1, cpha_i = 1'b0, lsb_first_i = 1'b0;
  logic [4:0] char_len_i = '0;
  logic [7:0] divider_i = '0;
  logic [1:0] cs_sel_i = '0;
  logic [31:0] tx_data_i = '0;
  logic miso_i, sclk_o, mosi_o, busy_o, done_o;
  logic [3:0] cs_n_o;
  logic [31:0] rx_data_o;
`ifdef SPI_LOOPBACK_EN
  logic loopback_i = 1'b0;
`endif
  logic tie = 1'b0, slv_miso = 1'b0;
  int n_cmp = 0, n_bad = 0;
  bit cfg_cpol, cfg_cpha, cfg_lsb;
  int cfg_len = 8;
  logic [31:0] cfg_word = '0, cap = '0, model_rx = '0;
  int k_in = 0, k_out = 0, nlead = 0;
  time t1 = 0, t2 = 0;
  bit mseq[$];
  bit sel_on = 1'b0;
  logic prev_sclk = 1'b0;
  assign miso_i = tie ? mosi_o : slv_miso;
  always #5 sysclk = ~sysclk;
  spi_master_core dut (
    .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .start_i(start_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
    .char_len_i(char_len_i), .divider_i(divider_i), .cs_sel_i(cs_sel_i),
    .tx_data_i(tx_data_i), .miso_i(miso_i),
`ifdef SPI_LOOPBACK_EN
    .loopback_i(loopback_i),
`endif
    .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o), .busy_o(busy_o),
    .done_o(done_o), .rx_data_o(rx_data_o)
  );
  function automatic int bpos(int k);
    return cfg_lsb ? k : cfg_len - 1 - k;
  endfunction
  function automatic logic sbit(int k);
    return k < cfg_len ? cfg_word[bpos(k)] : 1'b0;
  endfunction
  always @(cs_n_o or sclk_o) begin
    if (cs_n_o != 4'hF && !sel_on) begin
      k_in = 0;
      k_out = cfg_cpha ? 0 : 1;
      nlead = 0;
      cap = '0;
      mseq.delete();
      if (!cfg_cpha) slv_miso = sbit(0);
    end else if (cs_n_o != 4'hF && sclk_o != prev_sclk) begin
      if (sclk_o != cfg_cpol) begin
        nlead++;
        if (nlead == 1) t1 = $time;
        if (nlead == 2) t2 = $time;
      end
      if ((sclk_o != cfg_cpol) != cfg_cpha) begin
        if (k_in < cfg_len) cap[bpos(k_in)] = mosi_o;
        mseq.push_back(mosi_o);
        k_in++;
      end else begin
        slv_miso = sbit(k_out);
        k_out++;
      end
    end
    sel_on = cs_n_o != 4'hF;
    prev_sclk = sclk_o;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input bit cp, input bit ch, input bit lsb, input logic [4:0] lf,
                     input logic [7:0] dv, input logic [1:0] sel, input logic [31:0] tx,
                     input logic [31:0] sw, input bit tie_m, input bit lb, input bit dup,
                     input string nm);
    int len, lat, cyc, glitch;
    logic [31:0] mask, exp_rx;
    logic [3:0] ecs;
    len = lf == 0 ? 32 : int'(lf);
    lat = (2 * len + 2) * (int'(dv) + 1) + 2;
    mask = len == 32 ? 32'hFFFF_FFFF : (32'h1 << len) - 32'h1;
    exp_rx = ((tie_m || lb) ? tx : sw) & mask;
    ecs = ~(4'b1 << sel);
    @(negedge sysclk);
    cpol_i = cp;
    tie = tie_m;
`ifdef SPI_LOOPBACK_EN
    loopback_i = lb;
`endif
    cfg_cpol = cp; cfg_cpha = ch; cfg_lsb = lsb; cfg_len = len; cfg_word = sw;
    repeat (2) @(negedge sysclk);
    chk({nm, "_idle_pre"}, sclk_o, cp);
    cpha_i = ch; lsb_first_i = lsb; char_len_i = lf; divider_i = dv;
    cs_sel_i = sel; tx_data_i = tx; start_i = 1'b1;
    @(posedge sysclk); #1;
    start_i = 1'b0;
    cyc = 1;
    glitch = 0;
    tx_data_i = $urandom; cpha_i = 1'($urandom); lsb_first_i = 1'($urandom);
    char_len_i = 5'($urandom); divider_i = 8'($urandom); cs_sel_i = 2'($urandom);
    chk({nm, "_cs_lead"}, cs_n_o, ecs);
    chk({nm, "_busy"}, busy_o, 1'b1);
    while (!done_o && cyc < lat + 40) begin
      start_i = dup && cyc == 10;
      @(posedge sysclk); #1;
      cyc++;
      if (cs_n_o != ecs && cs_n_o != 4'hF) glitch++;
    end
    start_i = 1'b0;
    chk({nm, "_latency"}, cyc, lat);
    chk({nm, "_rx"}, rx_data_o, exp_rx);
    chk({nm, "_slave_rx"}, cap, tx & mask);
    chk({nm, "_leading_edges"}, nlead, len);
    chk({nm, "_cs_glitch"}, glitch, 0);
    chk({nm, "_cs_done"}, cs_n_o, 4'hF);
    chk({nm, "_busy_done"}, busy_o, 1'b0);
    @(posedge sysclk); #1;
    chk({nm, "_done_pulse"}, done_o, 1'b0);
    chk({nm, "_idle_post"}, sclk_o, cp);
    if (dup) begin
      repeat (5) @(posedge sysclk);
      #1;
      chk({nm, "_dup_ignored"}, {busy_o, cs_n_o}, {1'b0, 4'hF});
    end
    model_rx = exp_rx;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cyc;
    bit seen;
    logic [11:0] seq;
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_outputs", {sclk_o, mosi_o, cs_n_o, busy_o, done_o}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0});
    chk("reset_rx", rx_data_o, 32'h0);
    @(negedge sysclk);
    rst_n = 1'b1;
    enable = 1'b1;
    run(0, 0, 0, 5'd8, 8'd4, 2'd0, 32'hA5, 32'h0, 1, 0, 0, "mode0");
    run(0, 1, 0, 5'd8, 8'd2, 2'd1, 32'h00000096, 32'h3C, 0, 0, 0, "mode1");
    run(1, 0, 0, 5'd8, 8'd1, 2'd3, 32'h0000005E, 32'h3C, 0, 0, 0, "mode2");
    run(1, 1, 0, 5'd8, 8'd3, 2'd0, 32'h000000C3, 32'h3C, 0, 0, 0, "mode3");
    run(0, 0, 1, 5'd12, 8'd1, 2'd1, 32'h5A3, 32'hABC, 0, 0, 0, "lsb12");
    seq = '0;
    for (int i = 0; i < 12; i++) seq[11 - i] = i < mseq.size() ? mseq[i] : 1'b0;
    chk("lsb12_mosi_seq", seq, 12'b1100_0101_1010);
    run(0, 1, 0, 5'd0, 8'd0, 2'd0, 32'h1234_5678, 32'h0, 1, 0, 0, "len32_div0");
    chk("div0_sclk_period", t2 - t1, 20);
    run(1, 0, 0, 5'd16, 8'd2, 2'd2, 32'hBEEF, 32'h0, 1, 0, 1, "dup_sel2");
    for (int n = 0; n < 20; n++)
      run(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom_range(0, 3)),
          2'($urandom), $urandom, $urandom, 1'($urandom), 0, 0, "rand");
`ifdef SPI_LOOPBACK_EN
    run(0, 0, 0, 5'd0, 8'd0, 2'd0, 32'hFFFF_0001, 32'h0, 0, 1, 0, "loopback");
    @(negedge sysclk);
    loopback_i = 1'b0;
`endif
    @(negedge sysclk);
    cpol_i = 1'b0; tie = 1'b1;
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb = 0; cfg_len = 8;
    repeat (2) @(negedge sysclk);
    cpha_i = 0; lsb_first_i = 0; char_len_i = 5'd8; divider_i = 8'd2; cs_sel_i = 2'd1;
    tx_data_i = 32'h5C; start_i = 1'b1;
    @(posedge sysclk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (nlead < 4 && cyc < 500) begin
      @(posedge sysclk); #1;
      cyc++;
    end
    chk("abort_reached", nlead >= 4, 1'b1);
    enable = 1'b0;
    @(posedge sysclk); #1;
    chk("abort_cs", cs_n_o, 4'hF);
    chk("abort_sclk", sclk_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge sysclk); #1;
      if (done_o) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    chk("abort_rx_held", rx_data_o, model_rx);
    @(negedge sysclk);
    enable = 1'b1;
    run(1, 1, 1, 5'd7, 8'd0, 2'd3, 32'h55, 32'h2A, 0, 0, 0, "after_abort");
    @(negedge sysclk);
    cpol_i = 1'b1; tie = 1'b1;
    cfg_cpol = 1; cfg_cpha = 0; cfg_lsb = 0; cfg_len = 16;
    repeat (2) @(negedge sysclk);
    cpha_i = 0; char_len_i = 5'd16; divider_i = 8'd1; cs_sel_i = 2'd0;
    tx_data_i = 32'hFFFF; start_i = 1'b1;
    @(posedge sysclk); #1;
    start_i = 1'b0;
    repeat (30) @(posedge sysclk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {sclk_o, mosi_o, cs_n_o, busy_o, done_o}, {1'b0, 1'b0, 4'hF, 1'b0, 1'b0});
    chk("rst_mid_rx", rx_data_o, 32'h0);
    @(negedge sysclk);
    rst_n = 1'b1;
    model_rx = '0;
    run(0, 0, 0, 5'd4, 8'd1, 2'd2, 32'h9, 32'h6, 0, 0, 0, "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
